// File: rtl/morse_text_display.sv
`default_nettype none
// ============================================================================
// Module      : morse_text_display
// Description : Stores decoded Morse characters in a circular message buffer
//               and drives NUM_DIGITS active-low seven-segment digits.
//               The message is shown newest-right in typing mode, or as a
//               marquee in scroll mode.
//
// Ports
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   char_valid : single-cycle strobe, char_code holds a new character
//   char_code  : character code (0-9 digits, 10-35 A-Z, >=36 blank)
//   clear      : synchronous buffer clear (wins over char_valid)
//   scroll_en  : 1 = scroll mode, 0 = typing mode (level)
//   seg_out    : active-low segments, digit k at [7k+6:7k], order gfedcba
//   count      : number of stored characters
//   overflow   : sticky flag, a character was dropped
//
// Revision    : 1.0 - initial release
// ============================================================================
module morse_text_display #(
    parameter int NUM_DIGITS = 6,
    parameter int CODE_W     = 6,
    parameter int DEPTH      = 16,
    parameter int SCROLL_DIV = 25000000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         char_valid,
    input  logic [CODE_W-1:0]            char_code,
    input  logic                         clear,
    input  logic                         scroll_en,
    output logic [7*NUM_DIGITS-1:0]      seg_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam int c_ptr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_len_w  = $clog2(DEPTH + NUM_DIGITS + 1);
    // One extra bit so sums of two in-range indices never wrap.
    localparam int c_ar_w   = c_len_w + 1;
    localparam int c_tick_w = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CODE_W-1:0]       r_mem [DEPTH];
    logic [c_ptr_w-1:0]      r_wr_ptr;   // next free slot
    logic [c_ptr_w-1:0]      r_rd_ptr;   // oldest stored character
    logic [c_cnt_w-1:0]      r_count;
    logic                    r_overflow;
    logic [c_len_w-1:0]      r_pos;
    logic [c_tick_w-1:0]     r_tick;
    logic                    r_scroll_d; // scroll state seen last cycle
    logic [7*NUM_DIGITS-1:0] r_seg;

    logic                    w_write;
    logic                    w_full;
    logic                    w_scroll;
    logic [c_len_w-1:0]      w_len;
    logic                    w_tick_last;
    logic                    w_pos_last;
    logic [7*NUM_DIGITS-1:0] w_next_seg;

    assign seg_out  = r_seg;
    assign count    = r_count;
    assign overflow = r_overflow;

    assign w_write     = char_valid & ~clear;
    assign w_full      = (r_count == c_cnt_w'(DEPTH));
    assign w_len       = c_len_w'(r_count) + c_len_w'(NUM_DIGITS);
    assign w_scroll    = scroll_en && (r_count > c_cnt_w'(NUM_DIGITS));
    assign w_tick_last = (r_tick == c_tick_w'(SCROLL_DIV - 1));
    assign w_pos_last  = (r_pos == (w_len - 1'b1));

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Active-high gfedcba glyph for a character code; unknown codes blank.
    function automatic logic [6:0] glyph(input logic [CODE_W-1:0] c);
        logic [6:0] g;
        case (int'(c))
            0:  g = 7'h3F;  1:  g = 7'h06;  2:  g = 7'h5B;  3:  g = 7'h4F;
            4:  g = 7'h66;  5:  g = 7'h6D;  6:  g = 7'h7D;  7:  g = 7'h07;
            8:  g = 7'h7F;  9:  g = 7'h6F;
            10: g = 7'h77;  11: g = 7'h7C;  12: g = 7'h39;  13: g = 7'h5E;
            14: g = 7'h79;  15: g = 7'h71;  16: g = 7'h3D;  17: g = 7'h76;
            18: g = 7'h30;  19: g = 7'h1E;  20: g = 7'h75;  21: g = 7'h38;
            22: g = 7'h37;  23: g = 7'h54;  24: g = 7'h5C;  25: g = 7'h73;
            26: g = 7'h67;  27: g = 7'h50;  28: g = 7'h6D;  29: g = 7'h78;
            30: g = 7'h3E;  31: g = 7'h1C;  32: g = 7'h2A;  33: g = 7'h49;
            34: g = 7'h6E;  35: g = 7'h5B;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Per-digit character selection
    // Characters are addressed by sequence index s (0 = oldest), mapped
    // onto the circular buffer as (rd_ptr + s) mod DEPTH.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [c_ar_w-1:0]  w_t;
        logic [c_ar_w-1:0]  w_s;
        logic [c_ar_w-1:0]  w_sum;
        logic               w_vis;
        logic [c_ptr_w-1:0] w_idx;
        logic [6:0]         w_gly;

        always_comb begin
            w_t   = '0;
            w_s   = '0;
            w_vis = 1'b0;
            if (w_scroll) begin
                // Window onto S = message + NUM_DIGITS blanks, length L.
                // pos < L normally, so one conditional subtract suffices;
                // a transient pos >= L just shows blank until it wraps.
                w_t   = c_ar_w'(r_pos) + c_ar_w'(NUM_DIGITS - 1 - k);
                w_s   = (w_t >= c_ar_w'(w_len)) ? w_t - c_ar_w'(w_len) : w_t;
                w_vis = (w_s < c_ar_w'(r_count));
            end else begin
                // Digit k shows age k, i.e. sequence index count-1-k.
                w_s   = c_ar_w'(r_count) - c_ar_w'(k + 1);
                w_vis = (c_ar_w'(k) < c_ar_w'(r_count));
            end
            w_sum = c_ar_w'(r_rd_ptr) + w_s;
            if (w_sum >= c_ar_w'(DEPTH)) begin
                w_sum = w_sum - c_ar_w'(DEPTH);
            end
            w_idx = w_sum[c_ptr_w-1:0];
            w_gly = w_vis ? glyph(r_mem[w_idx]) : 7'h00;
        end

        assign w_next_seg[7*k +: 7] = ~w_gly;
    end

    // ------------------------------------------------------------------
    // Message storage (no reset needed: entries beyond count are ignored)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= char_code;
        end
    end

    // ------------------------------------------------------------------
    // Buffer bookkeeping, scroll timing and registered segment output
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_pos      <= '0;
            r_tick     <= '0;
            r_scroll_d <= 1'b0;
            r_seg      <= '1;
        end else begin
            r_seg      <= w_next_seg;
            r_scroll_d <= w_scroll;

            if (clear) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else if (w_write) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
                if (w_full) begin
                    // Drop the oldest entry to make room.
                    r_rd_ptr   <= ptr_inc(r_rd_ptr);
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Typing mode and the first scroll cycle both pin the marquee
            // to its start.
            if (clear || !w_scroll || !r_scroll_d) begin
                r_pos  <= '0;
                r_tick <= '0;
            end else begin
                r_tick <= w_tick_last ? '0 : r_tick + 1'b1;
                if (r_pos >= w_len) begin
                    r_pos <= '0;
                end else if (w_tick_last) begin
                    r_pos <= w_pos_last ? '0 : r_pos + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_morse_text_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_text_display
// Description : Directed self-checking bench for morse_text_display
//               (NUM_DIGITS=6, CODE_W=6, DEPTH=16, SCROLL_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_text_display;

    localparam int c_nd = 6;
    localparam logic [41:0] c_blank = {42{1'b1}};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        char_valid;
    logic [5:0]  char_code;
    logic        clear;
    logic        scroll_en;
    logic [41:0] seg_out;
    logic [4:0]  count;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    logic [41:0] exp;

    morse_text_display #(
        .NUM_DIGITS (c_nd),
        .CODE_W     (6),
        .DEPTH      (16),
        .SCROLL_DIV (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .char_valid (char_valid),
        .char_code  (char_code),
        .clear      (clear),
        .scroll_en  (scroll_en),
        .seg_out    (seg_out),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference glyphs for codes 0-15; anything else (-1) is blank.
    function automatic logic [6:0] ref_glyph(input int c);
        case (c)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    // Expected seg_out with digit5 (leftmost) first.
    function automatic logic [41:0] pat(input int d5, d4, d3, d2, d1, d0);
        int c [6];
        logic [41:0] v;
        c = '{d0, d1, d2, d3, d4, d5};
        v = '0;
        for (int k = 0; k < 6; k++) v[7*k +: 7] = ~ref_glyph(c[k]);
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_char(input int c);
        char_code  = 6'(c);
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; char_valid = 1'b0; char_code = '0;
        clear = 1'b0; scroll_en = 1'b0;
        step(2);
        total++; if (seg_out !== c_blank) begin bad++; $display("FAIL reset_seg got=%h want=%h", seg_out, c_blank); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        reset_n = 1'b1;
        step(2);
    endtask

    task automatic test_typing();
        write_char(1); write_char(2); write_char(3);
        step(1);
        exp = pat(-1, -1, -1, 1, 2, 3);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL typing_seg got=%h want=%h", seg_out, exp); end
        total++; if (seg_out[6:0] !== 7'h30) begin bad++; $display("FAIL typing_digit0 got=%h want=30", seg_out[6:0]); end
        total++; if (count !== 5'd3) begin bad++; $display("FAIL typing_count got=%0d want=3", count); end
    endtask

    task automatic test_overflow();
        pulse_clear();
        for (int i = 0; i < 16; i++) write_char(i);
        write_char(0);
        step(1);
        total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d want=16", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        // Ages 5..0 are codes 11,12,13,14,15,0.
        exp = pat(11, 12, 13, 14, 15, 0);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL ovf_seg got=%h want=%h", seg_out, exp); end
        write_char(5);
        total++; if (overflow !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL ovf_sticky got=%b/%0d want=1/16", overflow, count); end
        pulse_clear();
        total++; if (count !== 5'd0 || overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0d/%b want=0/0", count, overflow); end
        step(1);
        total++; if (seg_out !== c_blank) begin bad++; $display("FAIL ovf_clear_seg got=%h want=%h", seg_out, c_blank); end
    endtask

    task automatic test_scroll();
        pulse_clear();
        for (int i = 0; i < 8; i++) write_char(i);
        step(1);
        scroll_en = 1'b1;
        step(1);   // first scroll edge: pos 0
        exp = pat(0, 1, 2, 3, 4, 5);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL scroll_pos0 got=%h want=%h", seg_out, exp); end
        step(4);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL scroll_pos0_hold got=%h want=%h", seg_out, exp); end
        step(1);
        exp = pat(1, 2, 3, 4, 5, 6);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL scroll_pos1 got=%h want=%h", seg_out, exp); end
        step(24);
        exp = pat(7, -1, -1, -1, -1, -1);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL scroll_pos7 got=%h want=%h", seg_out, exp); end
        step(24);
        exp = pat(-1, 0, 1, 2, 3, 4);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL scroll_pos13 got=%h want=%h", seg_out, exp); end
        step(4);
        exp = pat(0, 1, 2, 3, 4, 5);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL scroll_wrap got=%h want=%h", seg_out, exp); end
        step(12);
        exp = pat(3, 4, 5, 6, 7, -1);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL scroll_pos3 got=%h want=%h", seg_out, exp); end
        write_char(8);
        total++; if (count !== 5'd9) begin bad++; $display("FAIL scroll_wr_count got=%0d want=9", count); end
        step(1);
        exp = pat(3, 4, 5, 6, 7, 8);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL scroll_wr_pos3 got=%h want=%h", seg_out, exp); end
        step(38);
        exp = pat(-1, -1, 0, 1, 2, 3);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL scroll_l15_pos13 got=%h want=%h", seg_out, exp); end
        step(4);
        exp = pat(-1, 0, 1, 2, 3, 4);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL scroll_l15_pos14 got=%h want=%h", seg_out, exp); end
        step(4);
        exp = pat(0, 1, 2, 3, 4, 5);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL scroll_l15_wrap got=%h want=%h", seg_out, exp); end
        scroll_en = 1'b0;
        step(1);
        exp = pat(3, 4, 5, 6, 7, 8);
        total++; if (seg_out !== exp) begin bad++; $display("FAIL scroll_off_typing got=%h want=%h", seg_out, exp); end
    endtask

    task automatic test_clear_priority();
        clear = 1'b1; char_valid = 1'b1; char_code = 6'd5;
        @(negedge clk);
        clear = 1'b0; char_valid = 1'b0;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL clrpri_count got=%0d want=0", count); end
        step(1);
        total++; if (seg_out !== c_blank) begin bad++; $display("FAIL clrpri_seg got=%h want=%h", seg_out, c_blank); end
        write_char(2);
        step(1);
        exp = pat(-1, -1, -1, -1, -1, 2);
        total++; if (seg_out !== exp || count !== 5'd1) begin bad++; $display("FAIL clrpri_after got=%h/%0d want=%h/1", seg_out, count, exp); end
    endtask

    task automatic test_blank_codes();
        pulse_clear();
        write_char(36); write_char(63);
        step(1);
        total++; if (seg_out !== c_blank) begin bad++; $display("FAIL blank_seg got=%h want=%h", seg_out, c_blank); end
        total++; if (count !== 5'd2) begin bad++; $display("FAIL blank_count got=%0d want=2", count); end
    endtask

    task automatic test_reset_mid_scroll();
        pulse_clear();
        for (int i = 0; i < 10; i++) write_char(i);
        scroll_en = 1'b1;
        step(7);
        #2 reset_n = 1'b0;
        #1;
        total++; if (seg_out !== c_blank) begin bad++; $display("FAIL rstmid_seg got=%h want=%h", seg_out, c_blank); end
        total++; if (count !== 5'd0 || overflow !== 1'b0) begin bad++; $display("FAIL rstmid_state got=%0d/%b want=0/0", count, overflow); end
        @(negedge clk);
        reset_n = 1'b1;
        step(5);
        total++; if (seg_out !== c_blank || count !== 5'd0) begin bad++; $display("FAIL rstmid_after got=%h/%0d want=%h/0", seg_out, count, c_blank); end
        scroll_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_typing();
        test_overflow();
        test_scroll();
        test_clear_priority();
        test_blank_codes();
        test_reset_mid_scroll();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
